// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the burst RAM core.
//   state_e        : burst engine states
//   BE_W           : byte-enable width for the default 8-bit data path
//   next_addr()    : address increment with wrap modulo SIZE (in range) or
//                    modulo 2**aw (out-of-range start addresses)
package sp_ram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned BE_W          = DEF_DATAWIDTH / 8;

  // Next burst address: in-range addresses wrap at size, out-of-range ones
  // keep counting until they roll over the full address space.
  function automatic int unsigned next_addr(input int unsigned a,
                                            input int unsigned size,
                                            input int unsigned aw);
    int unsigned nxt;
    nxt = a + 32'd1;
    if (a < size) begin
      return (nxt >= size) ? 32'd0 : nxt;
    end
    return (nxt >= (32'd1 << aw)) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/sp_ram_burst_array.sv
// Storage for the burst RAM: byte-enable write port, registered read port,
// out-of-range masking. The memory array itself is never reset.
//   wr_en/rd_en : beat strobes from the burst engine
//   addr        : beat address (may be >= SIZE)
//   be/wdata    : byte enables and write data
//   rdata       : registered read data, zero for out-of-range reads
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SIZE      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic [DATAWIDTH/8-1:0] be,
  input  logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH-1:0]   rdata
);

  localparam int unsigned BYTES = DATAWIDTH / 8;

  logic [DATAWIDTH-1:0] mem [SIZE];
  logic                 in_range_c;

  assign in_range_c = (32'(addr) < SIZE);

  // Byte-masked write; out-of-range beats are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && in_range_c) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; holds when no read beat occurs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= in_range_c ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/sp_ram_burst.sv
// Single-port RAM with auto-incrementing burst engine.
//   cs/we/addr/burst_len : command, sampled in IDLE
//   be/wdata             : per-beat write payload
//   oe                   : per-read-beat pad output enable request
//   rdata/rdata_valid    : registered read result (latency 1)
//   data_oen             : active-low pad output enable, aligned with rdata
//   busy                 : burst in progress (decoded from state)
module sp_ram_burst
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDRWIDTH  = 4,
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned SIZE       = 16,
  parameter int unsigned BURSTWIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic                   we,
  input  logic                   oe,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic [BURSTWIDTH-1:0]  burst_len,
  input  logic [DATAWIDTH/8-1:0] be,
  input  logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic                   rdata_valid,
  output logic                   data_oen,
  output logic                   busy
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_BURST = BURST;

  logic [0:0]            state, state_n;
  logic [ADDRWIDTH-1:0]  addr_cnt, addr_cnt_n;
  logic [BURSTWIDTH-1:0] rem, rem_n;
  logic                  we_lat, we_lat_n;
  logic                  beat, beat_we;
  logic [ADDRWIDTH-1:0]  beat_addr;
  logic                  wr_en, rd_en;

  // Next-state and beat decode. Beat 0 runs in the accept cycle, so the
  // remaining count loaded here already excludes it.
  always_comb begin
    state_n    = state;
    addr_cnt_n = addr_cnt;
    rem_n      = rem;
    we_lat_n   = we_lat;
    beat       = 1'b0;
    beat_we    = we_lat;
    beat_addr  = addr_cnt;
    case (state)
      S_IDLE: begin
        if (cs) begin
          beat       = 1'b1;
          beat_we    = we;
          beat_addr  = addr;
          we_lat_n   = we;
          addr_cnt_n = ADDRWIDTH'(next_addr(32'(addr), SIZE, ADDRWIDTH));
          if (burst_len != '0) begin
            rem_n   = burst_len - BURSTWIDTH'(1);
            state_n = S_BURST;
          end
        end
      end
      S_BURST: begin
        beat       = 1'b1;
        addr_cnt_n = ADDRWIDTH'(next_addr(32'(addr_cnt), SIZE, ADDRWIDTH));
        rem_n      = rem - BURSTWIDTH'(1);
        if (rem == '0) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A write beat coinciding with reset is suppressed.
  assign wr_en = beat & beat_we & rst_n;
  assign rd_en = beat & ~beat_we;
  assign busy  = (state == S_BURST);

  // State, counters and read-side status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_cnt    <= '0;
      rem         <= '0;
      we_lat      <= 1'b0;
      rdata_valid <= 1'b0;
      data_oen    <= 1'b1;
    end else begin
      state       <= state_n;
      addr_cnt    <= addr_cnt_n;
      rem         <= rem_n;
      we_lat      <= we_lat_n;
      rdata_valid <= rd_en;
      data_oen    <= ~(rd_en & oe);
    end
  end

  sp_ram_array #(
    .ADDRWIDTH (ADDRWIDTH),
    .DATAWIDTH (DATAWIDTH),
    .SIZE      (SIZE)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (beat_addr),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sp_ram_burst.sv
// Testbench for sp_ram_burst: an 8-bit/16-word instance and a
// 16-bit/12-word instance, checked against an array-based reference model.
module tb_sp_ram_burst;

  logic        clk = 1'b0;
  logic        rst_n, cs0, cs1, we, oe;
  logic [3:0]  addr, blen;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [7:0]  rdata0;
  logic [15:0] rdata1;
  logic        rv0, oen0, busy0, rv1, oen1, busy1;

  always #5 clk = ~clk;

  sp_ram_burst #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(16), .BURSTWIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs0), .we(we), .oe(oe), .addr(addr),
    .burst_len(blen), .be(be[0:0]), .wdata(wdata[7:0]), .rdata(rdata0),
    .rdata_valid(rv0), .data_oen(oen0), .busy(busy0));

  sp_ram_burst #(.ADDRWIDTH(4), .DATAWIDTH(16), .SIZE(12), .BURSTWIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs1), .we(we), .oe(oe), .addr(addr),
    .burst_len(blen), .be(be), .wdata(wdata), .rdata(rdata1),
    .rdata_valid(rv1), .data_oen(oen1), .busy(busy1));

  int nchk = 0;
  int nfail = 0;

  // per-beat stimulus and post-edge samples
  logic [1:0]  be_q [16];
  logic [15:0] wd_q [16];
  logic        oe_q [16];
  logic [15:0] s_rd [16];
  logic        s_rv [16];
  logic        s_oen[16];
  logic        s_busy[16];

  // reference memories
  logic [15:0] m0 [16];
  logic [15:0] m1 [12];

  function automatic int msize(input int sel);
    return (sel != 0) ? 12 : 16;
  endfunction

  // Address of beat k of a burst starting at start.
  function automatic int addr_at(input int sel, input int start, input int k);
    int a = start;
    for (int i = 0; i < k; i++) a = (a < msize(sel)) ? (a + 1) % msize(sel) : (a + 1) % 16;
    return a;
  endfunction

  function automatic logic [15:0] exp_rd(input int sel, input int a);
    if (a >= msize(sel)) return 16'h0;
    return (sel != 0) ? m1[a] : {8'h00, m0[a][7:0]};
  endfunction

  // Apply beats [0, upto) of a write burst to the model.
  task automatic model_write(input int sel, input int start, input int len, input int upto);
    int a;
    for (int k = 0; k <= len && k < upto; k++) begin
      a = addr_at(sel, start, k);
      if (a < msize(sel)) begin
        for (int b = 0; b < ((sel != 0) ? 2 : 1); b++) begin
          if (be_q[k][b]) begin
            if (sel != 0) m1[a][8*b +: 8] = wd_q[k][8*b +: 8];
            else          m0[a][8*b +: 8] = wd_q[k][8*b +: 8];
          end
        end
      end
    end
  endtask

  // Drive one burst beat per cycle; optionally re-strobe cs at beat cs_k with
  // address alt, or pull reset low at beat rst_k (burst abandoned there).
  task automatic run(input int sel, input logic w, input int start, input int len,
                     input int cs_k, input int alt, input int rst_k);
    for (int k = 0; k <= len; k++) begin
      cs0   = (sel == 0) && (k == 0 || k == cs_k);
      cs1   = (sel != 0) && (k == 0 || k == cs_k);
      we    = w;
      addr  = (k == 0) ? 4'(start) : 4'(alt);
      blen  = 4'(len);
      be    = be_q[k];
      wdata = wd_q[k];
      oe    = oe_q[k];
      rst_n = (k != rst_k);
      @(posedge clk); #1;
      s_rd[k]   = (sel != 0) ? rdata1 : {8'h00, rdata0};
      s_rv[k]   = (sel != 0) ? rv1 : rv0;
      s_oen[k]  = (sel != 0) ? oen1 : oen0;
      s_busy[k] = (sel != 0) ? busy1 : busy0;
      if (k == rst_k) break;
    end
    cs0 = 1'b0; cs1 = 1'b0; rst_n = 1'b1; oe = 1'b0; be = 2'b00;
  endtask

  task automatic set_beats(input logic [1:0] b, input logic [15:0] base, input logic o);
    for (int k = 0; k < 16; k++) begin
      be_q[k] = b; wd_q[k] = base + 16'(k); oe_q[k] = o;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; we = 1'b0; oe = 1'b0;
    addr = '0; blen = '0; be = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    nchk++; if ({rdata0, rv0, oen0, busy0} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL reset0: got %h/%b/%b/%b want 00/0/1/0", rdata0, rv0, oen0, busy0);
    end
    nchk++; if ({rdata1, rv1, oen1, busy1} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL reset1: got %h/%b/%b/%b want 0000/0/1/0", rdata1, rv1, oen1, busy1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    set_beats(2'b01, 16'h00A5, 1'b1);
    run(0, 1'b1, 3, 0, -1, 0, -1);
    model_write(0, 3, 0, 1);
    nchk++; if (s_busy[0] !== 1'b0) begin nfail++; $display("FAIL single_wr_busy: got %b want 0", s_busy[0]); end
    run(0, 1'b0, 3, 0, -1, 0, -1);
    nchk++; if ({s_rd[0], s_rv[0], s_oen[0], s_busy[0]} !== {16'h00A5, 1'b1, 1'b0, 1'b0}) begin
      nfail++; $display("FAIL single_rd: got %h/%b/%b/%b want 00a5/1/0/0", s_rd[0], s_rv[0], s_oen[0], s_busy[0]);
    end
    @(posedge clk); #1;
    nchk++; if ({rdata0, rv0, oen0} !== {8'hA5, 1'b0, 1'b1}) begin
      nfail++; $display("FAIL single_hold: got %h/%b/%b want a5/0/1", rdata0, rv0, oen0);
    end
  endtask

  task automatic test_wrap;
    set_beats(2'b01, 16'h0001, 1'b1);
    run(0, 1'b1, 14, 3, -1, 0, -1);
    model_write(0, 14, 3, 4);
    for (int k = 0; k < 4; k++) begin
      nchk++; if (s_busy[k] !== (k < 3)) begin nfail++; $display("FAIL wrap_wr_busy[%0d]: got %b want %b", k, s_busy[k], k < 3); end
    end
    run(0, 1'b0, 14, 3, -1, 0, -1);
    for (int k = 0; k < 4; k++) begin
      nchk++; if ({s_rd[k], s_rv[k], s_oen[k], s_busy[k]} !== {16'(k + 1), 1'b1, 1'b0, 1'(k < 3)}) begin
        nfail++; $display("FAIL wrap_rd[%0d]: got %h/%b/%b/%b want %h/1/0/%b", k, s_rd[k], s_rv[k], s_oen[k], s_busy[k], 16'(k + 1), k < 3);
      end
    end
  endtask

  task automatic test_byte_en;
    set_beats(2'b11, 16'h1234, 1'b1);
    run(1, 1'b1, 5, 0, -1, 0, -1);
    model_write(1, 5, 0, 1);
    set_beats(2'b01, 16'hABCD, 1'b1);
    run(1, 1'b1, 5, 0, -1, 0, -1);
    model_write(1, 5, 0, 1);
    run(1, 1'b0, 5, 0, -1, 0, -1);
    nchk++; if ({s_rd[0], s_rv[0]} !== {16'h12CD, 1'b1}) begin
      nfail++; $display("FAIL byte_en: got %h/%b want 12cd/1", s_rd[0], s_rv[0]);
    end
  endtask

  task automatic test_cs_busy;
    set_beats(2'b01, 16'h0050, 1'b1);
    run(0, 1'b1, 2, 3, -1, 0, -1);
    model_write(0, 2, 3, 4);
    set_beats(2'b01, 16'h0080, 1'b1);
    run(0, 1'b1, 8, 3, 1, 2, -1);
    model_write(0, 8, 3, 4);
    run(0, 1'b0, 8, 3, 1, 2, -1);
    for (int k = 0; k < 4; k++) begin
      nchk++; if ({s_rd[k], s_rv[k]} !== {exp_rd(0, 8 + k), 1'b1}) begin
        nfail++; $display("FAIL cs_busy_rd[%0d]: got %h/%b want %h/1", k, s_rd[k], s_rv[k], exp_rd(0, 8 + k));
      end
    end
    run(0, 1'b0, 2, 3, -1, 0, -1);
    for (int k = 0; k < 4; k++) begin
      nchk++; if (s_rd[k] !== exp_rd(0, 2 + k)) begin
        nfail++; $display("FAIL cs_busy_keep[%0d]: got %h want %h", k, s_rd[k], exp_rd(0, 2 + k));
      end
    end
  endtask

  task automatic test_reset_mid;
    set_beats(2'b01, 16'h00EE, 1'b1);
    for (int k = 0; k < 16; k++) wd_q[k] = 16'h00EE;
    run(0, 1'b1, 0, 7, -1, 0, -1);
    model_write(0, 0, 7, 8);
    run(0, 1'b0, 0, 0, -1, 0, -1);
    for (int k = 0; k < 16; k++) wd_q[k] = 16'($urandom_range(0, 255));
    run(0, 1'b1, 0, 7, -1, 0, 2);
    model_write(0, 0, 7, 2);
    nchk++; if ({s_busy[0], s_busy[1]} !== 2'b11) begin
      nfail++; $display("FAIL rstmid_busy_pre: got %b%b want 11", s_busy[0], s_busy[1]);
    end
    nchk++; if ({s_rd[2], s_rv[2], s_oen[2], s_busy[2]} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL rstmid_out: got %h/%b/%b/%b want 0000/0/1/0", s_rd[2], s_rv[2], s_oen[2], s_busy[2]);
    end
    run(0, 1'b0, 0, 7, -1, 0, -1);
    for (int k = 0; k < 8; k++) begin
      nchk++; if (s_rd[k] !== exp_rd(0, k)) begin
        nfail++; $display("FAIL rstmid_rd[%0d]: got %h want %h", k, s_rd[k], exp_rd(0, k));
      end
    end
  endtask

  task automatic test_oor;
    set_beats(2'b11, 16'h0000, 1'b0);
    run(1, 1'b0, 13, 0, -1, 0, -1);
    nchk++; if ({s_rd[0], s_rv[0], s_oen[0]} !== {16'h0000, 1'b1, 1'b1}) begin
      nfail++; $display("FAIL oor_rd: got %h/%b/%b want 0000/1/1", s_rd[0], s_rv[0], s_oen[0]);
    end
    for (int k = 0; k < 16; k++) wd_q[k] = 16'($urandom);
    run(1, 1'b1, 13, 4, -1, 0, -1);
    model_write(1, 13, 4, 5);
    for (int k = 0; k < 16; k++) oe_q[k] = 1'($urandom);
    run(1, 1'b0, 13, 5, -1, 0, -1);
    for (int k = 0; k < 6; k++) begin
      nchk++; if ({s_rd[k], s_rv[k], s_oen[k]} !== {exp_rd(1, addr_at(1, 13, k)), 1'b1, ~oe_q[k]}) begin
        nfail++; $display("FAIL oor_burst[%0d]: got %h/%b/%b want %h/1/%b", k, s_rd[k], s_rv[k], s_oen[k],
                          exp_rd(1, addr_at(1, 13, k)), ~oe_q[k]);
      end
    end
  endtask

  task automatic test_random;
    int sel, start, len;
    logic w;
    // make every word known in both models first
    for (int k = 0; k < 16; k++) begin be_q[k] = 2'b11; wd_q[k] = 16'($urandom); end
    run(0, 1'b1, 0, 15, -1, 0, -1); model_write(0, 0, 15, 16);
    run(1, 1'b1, 0, 11, -1, 0, -1); model_write(1, 0, 11, 12);
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 1));
      w = 1'($urandom);
      start = int'($urandom_range(0, 15));
      len = int'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        be_q[k] = 2'($urandom); wd_q[k] = 16'($urandom); oe_q[k] = 1'($urandom);
      end
      run(sel, w, start, len, -1, 0, -1);
      if (w) model_write(sel, start, len, 16);
      for (int k = 0; k <= len; k++) begin
        nchk++; if (s_busy[k] !== (k < len)) begin
          nfail++; $display("FAIL rand_busy[%0d.%0d]: got %b want %b", it, k, s_busy[k], k < len);
        end
        if (!w) begin
          nchk++; if ({s_rd[k], s_rv[k], s_oen[k]} !== {exp_rd(sel, addr_at(sel, start, k)), 1'b1, ~oe_q[k]}) begin
            nfail++; $display("FAIL rand_rd[%0d.%0d]: got %h/%b/%b want %h/1/%b", it, k, s_rd[k], s_rv[k], s_oen[k],
                              exp_rd(sel, addr_at(sel, start, k)), ~oe_q[k]);
          end
        end
      end
    end
    run(0, 1'b0, 0, 15, -1, 0, -1);
    for (int k = 0; k < 16; k++) begin
      nchk++; if (s_rd[k] !== exp_rd(0, k)) begin nfail++; $display("FAIL final0[%0d]: got %h want %h", k, s_rd[k], exp_rd(0, k)); end
    end
    run(1, 1'b0, 0, 11, -1, 0, -1);
    for (int k = 0; k < 12; k++) begin
      nchk++; if (s_rd[k] !== exp_rd(1, k)) begin nfail++; $display("FAIL final1[%0d]: got %h want %h", k, s_rd[k], exp_rd(1, k)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_byte_en();
    test_cs_busy();
    test_reset_mid();
    test_oor();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
